// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported synchronous data memory between the
// CPU memory-access stage and the program/debug loader. One grant per cycle,
// CPU preferred, loader protected by a starvation counter and a lock mode.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_ARB  | normal arbitration, CPU wins ties unless loader is starved
// S_LOCK | loader owns the memory while LdLock=1, CPU is held off
module dmem_arbiter #(
    parameter int DMEM_SIZE  = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic                         CLK,
    input  logic                         RST,

    input  logic                         CpuReq,
    input  logic                         CpuWe,
    input  logic [31:0]                  CpuAddr,
    input  logic [31:0]                  CpuWdata,
    output logic                         CpuGnt,
    output logic                         CpuStall,
    output logic                         CpuRvalid,
    output logic [31:0]                  CpuRdata,
    output logic                         CpuErr,

    input  logic                         LdReq,
    input  logic                         LdWe,
    input  logic [31:0]                  LdAddr,
    input  logic [31:0]                  LdWdata,
    input  logic                         LdLock,
    output logic                         LdGnt,
    output logic                         LdRvalid,
    output logic [31:0]                  LdRdata,
    output logic                         LdErr,

    output logic                         MemEn,
    output logic                         MemWe,
    output logic [$clog2(DMEM_SIZE)-1:0] MemAddr,
    output logic [31:0]                  MemWdata,
    input  logic [31:0]                  MemRdata
);

    localparam int          AW         = $clog2(DMEM_SIZE);
    localparam logic [31:0] DEPTH      = 32'(DMEM_SIZE);
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        S_ARB  = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;

    logic       cpu_gnt, ld_gnt;
    logic       arb_mode;
    logic       cpu_in_range, ld_in_range;

    // response tracking: one in-flight memory read plus its owner (1 = loader)
    logic       rd_pend;
    logic       rd_owner;
    logic       cpu_oor_rd, ld_oor_rd;
    logic       cpu_err_q, ld_err_q;

    // address bits [1:0] are don't-care for word accesses
    logic       unused_addr_bits;
    assign unused_addr_bits = &{1'b0, CpuAddr[1:0], LdAddr[1:0]};

    // word index range check for both requesters
    always_comb begin
        cpu_in_range = {2'b00, CpuAddr[31:2]} < DEPTH;
        ld_in_range  = {2'b00, LdAddr[31:2]} < DEPTH;
    end

    // state and starvation counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_ARB;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // grant decision, next state and starvation count; grants are held off
    // while reset is asserted so every output reads 0 during reset
    always_comb begin
        state_nxt      = state;
        cpu_gnt        = 1'b0;
        ld_gnt         = 1'b0;
        starve_cnt_nxt = 4'd0;
        // a lock cycle with LdLock dropped arbitrates exactly like S_ARB
        arb_mode       = (state == S_ARB) || !LdLock;

        if (!RST) begin
            if (!arb_mode) begin
                ld_gnt = LdReq;
            end else begin
                if (CpuReq && LdReq) begin
                    ld_gnt  = (starve_cnt == STARVE_LIM);
                    cpu_gnt = !ld_gnt;
                end else begin
                    cpu_gnt = CpuReq;
                    ld_gnt  = LdReq;
                end
                state_nxt = (ld_gnt && LdLock) ? S_LOCK : S_ARB;
            end

            if (LdReq && !ld_gnt) begin
                starve_cnt_nxt = (starve_cnt >= STARVE_LIM) ? STARVE_LIM
                                                            : starve_cnt + 4'd1;
            end
        end
    end

    // memory port: driven straight from the granted requester, idle is all 0
    always_comb begin
        MemEn    = 1'b0;
        MemWe    = 1'b0;
        MemAddr  = '0;
        MemWdata = '0;
        if (cpu_gnt && cpu_in_range) begin
            MemEn    = 1'b1;
            MemWe    = CpuWe;
            MemAddr  = CpuAddr[AW+1:2];
            MemWdata = CpuWdata;
        end else if (ld_gnt && ld_in_range) begin
            MemEn    = 1'b1;
            MemWe    = LdWe;
            MemAddr  = LdAddr[AW+1:2];
            MemWdata = LdWdata;
        end
    end

    // record who owns the next-cycle response and any out-of-range error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
            cpu_oor_rd <= 1'b0;
            ld_oor_rd  <= 1'b0;
            cpu_err_q  <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            rd_pend    <= (cpu_gnt && cpu_in_range && !CpuWe) ||
                          (ld_gnt && ld_in_range && !LdWe);
            rd_owner   <= ld_gnt;
            cpu_oor_rd <= cpu_gnt && !cpu_in_range && !CpuWe;
            ld_oor_rd  <= ld_gnt && !ld_in_range && !LdWe;
            cpu_err_q  <= cpu_gnt && !cpu_in_range;
            ld_err_q   <= ld_gnt && !ld_in_range;
        end
    end

    // response routing; read data comes from the memory's own output register
    always_comb begin
        CpuGnt    = cpu_gnt;
        LdGnt     = ld_gnt;
        CpuStall  = CpuReq && !cpu_gnt && !RST;
        CpuRvalid = (rd_pend && !rd_owner) || cpu_oor_rd;
        LdRvalid  = (rd_pend && rd_owner) || ld_oor_rd;
        CpuRdata  = (rd_pend && !rd_owner) ? MemRdata : 32'd0;
        LdRdata   = (rd_pend && rd_owner) ? MemRdata : 32'd0;
        CpuErr    = cpu_err_q;
        LdErr     = ld_err_q;
    end

    a_one_grant: assert property (@(posedge CLK) disable iff (RST) !(cpu_gnt && ld_gnt));

endmodule
